snake_control: RTL

Sequencing FSM for the snake game, sitting directly upstream of the snake datapath: it generates every datapath strobe, the 4-bit pixel sub-counter, the latched movement direction and the pixel colour. Per game tick it advances the head, shifts the body RAM, erases the old tail, redraws the snake and food, and handles growth and death. Datapath status (`isDead`, `inc_length`) feeds back into it; `plotEn`/`x`/`y` from the datapath plus `colour` from this block drive the VGA adapter.

---
 rtl/snake_pkg.sv | 44 ++++
 rtl/snake_tick_gen.sv | 37 +++
 rtl/snake_control.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game control path.
package snake_pkg;

    localparam logic [2:0] DIR_UP    = 3'b100;
    localparam logic [2:0] DIR_DOWN  = 3'b110;
    localparam logic [2:0] DIR_LEFT  = 3'b000;
    localparam logic [2:0] DIR_RIGHT = 3'b001;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_SNAKE = 3'b010;
    localparam logic [2:0] COL_HEAD  = 3'b111;
    localparam logic [2:0] COL_FOOD  = 3'b100;

    localparam int unsigned CELL_PIXELS = 16;

    typedef enum logic [3:0] {
        StClear, StInit, StIdle, StWait, StMove, StCheck, StLdPrev, StShRd,
        StShLd, StShWr, StShMv, StTail, StDrawRd, StDraw, StFood, StDead
    } state_e;

    typedef struct packed {
        logic reset_ram;
        logic ld_head;
        logic ld_q_def;
        logic inc_address;
        logic rst_address;
        logic update_head;
        logic ld_head_into_prev;
        logic ld_q_into_curr;
        logic ld_prev_into_q;
        logic ld_curr_into_prev;
        logic draw_q;
        logic draw_curr;
        logic food_en;
        logic lock;
        logic check_inc;
    } strobe_t;

    // Same axis but different code means a 180-degree reversal.
    function automatic logic dir_opposite(input logic [2:0] a, input logic [2:0] b);
        return (a[2] == b[2]) && (a != b);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game tick counter: counts while enabled, holds while paused, pulses on the terminal count.
module snake_tick_gen #(
    parameter int unsigned TICK_CYCLES = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_pause,
    output logic o_tick
);

    localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CntW-1:0] Last = CntW'(TICK_CYCLES - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (!i_en) begin
            w_cnt_d = '0;
        end else if (!i_pause) begin
            w_cnt_d = (r_cnt == Last) ? '0 : r_cnt + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_tick = i_en && !i_pause && (r_cnt == Last);

endmodule

// File: rtl/snake_control.sv
// Snake game sequencing FSM driving the datapath strobes, pixel counter, direction and colour.
// Optional SNAKE_PAUSE_EN adds a pause input that freezes the tick counter in WAIT.
module snake_control
    import snake_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 2_500_000,
    parameter int unsigned INIT_LEN    = 4,
    parameter int unsigned MAX_LEN     = 64
) (
    input  logic       clk,
    input  logic       rst,
`ifdef SNAKE_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       start,
    input  logic       isDead,
    input  logic       inc_length,
    output logic       reset_ram,
    output logic       ld_head,
    output logic       ld_q_def,
    output logic       inc_address,
    output logic       rst_address,
    output logic       update_head,
    output logic       ld_head_into_prev,
    output logic       ld_q_into_curr,
    output logic       ld_prev_into_q,
    output logic       ld_curr_into_prev,
    output logic       draw_q,
    output logic       draw_curr,
    output logic       food_en,
    output logic       lock,
    output logic       check_inc,
    output logic [3:0] cnt_status,
    output logic [2:0] dir,
    output logic [2:0] colour,
    output logic [6:0] length
);

    localparam logic [7:0] ClrLast  = 8'(MAX_LEN + 1);
    localparam logic [7:0] InitLast = 8'(INIT_LEN);
    localparam logic [7:0] PixLast  = 8'(CELL_PIXELS - 1);
    localparam logic [6:0] LenInit  = 7'(INIT_LEN);
    localparam logic [6:0] LenMax   = 7'(MAX_LEN);

    state_e     r_state;
    state_e     w_state_d;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_d;
    logic [6:0] r_seg;
    logic [6:0] w_seg_d;
    logic [6:0] r_length;
    logic [6:0] w_length_d;
    logic [2:0] r_dir;
    logic [2:0] w_dir_d;
    logic [2:0] w_key_dir;
    logic [2:0] w_dir_req;
    logic       r_start_q;
    logic       w_tick;
    logic       w_pause;
    logic       w_last_seg;

    strobe_t    r_strb;
    strobe_t    w_strb;
    logic [3:0] r_cnt_status;
    logic [3:0] w_cnt_status;
    logic [2:0] r_colour;
    logic [2:0] w_colour;

`ifdef SNAKE_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    snake_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state == StWait),
        .i_pause(w_pause),
        .o_tick (w_tick)
    );

    always_comb begin
        w_key_dir = r_dir;
        if (key_up) begin
            w_key_dir = DIR_UP;
        end else if (key_down) begin
            w_key_dir = DIR_DOWN;
        end else if (key_left) begin
            w_key_dir = DIR_LEFT;
        end else if (key_right) begin
            w_key_dir = DIR_RIGHT;
        end
        w_dir_req = dir_opposite(w_key_dir, r_dir) ? r_dir : w_key_dir;
    end

    assign w_last_seg = (r_seg == r_length - 7'd1);

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_seg_d    = r_seg;
        w_length_d = r_length;
        w_dir_d    = r_dir;
        unique case (r_state)
            StClear: begin
                if (r_cnt == ClrLast) begin
                    w_state_d  = StInit;
                    w_cnt_d    = '0;
                    w_length_d = LenInit;
                    w_dir_d    = DIR_UP;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            StInit: begin
                if (r_cnt == InitLast) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            StIdle: begin
                if (start) begin
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (w_tick) begin
                    w_state_d = StMove;
                    w_dir_d   = w_dir_req;
                end
            end
            StMove: w_state_d = StCheck;
            StCheck: begin
                if (isDead) begin
                    w_state_d = StDead;
                end else begin
                    w_state_d = StLdPrev;
                    if (inc_length && (r_length < LenMax)) begin
                        w_length_d = r_length + 7'd1;
                    end
                end
            end
            StLdPrev: begin
                w_state_d = StShRd;
                w_seg_d   = '0;
            end
            StShRd: w_state_d = StShLd;
            StShLd: w_state_d = StShWr;
            StShWr: w_state_d = StShMv;
            StShMv: begin
                if (w_last_seg) begin
                    w_state_d = StTail;
                    w_cnt_d   = '0;
                end else begin
                    w_state_d = StShRd;
                    w_seg_d   = r_seg + 7'd1;
                end
            end
            StTail: begin
                if (r_cnt == PixLast) begin
                    w_state_d = StDrawRd;
                    w_cnt_d   = '0;
                    w_seg_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            StDrawRd: begin
                w_state_d = StDraw;
                w_cnt_d   = '0;
            end
            StDraw: begin
                if (r_cnt == PixLast) begin
                    w_cnt_d = '0;
                    if (w_last_seg) begin
                        w_state_d = StFood;
                    end else begin
                        w_state_d = StDrawRd;
                        w_seg_d   = r_seg + 7'd1;
                    end
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            StFood: begin
                if (r_cnt == PixLast) begin
                    w_cnt_d   = '0;
                    w_state_d = isDead ? StDead : StWait;
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            StDead: begin
                // Skip the entry slot so the first CLEAR cycle already carries rst_address.
                if (start && !r_start_q) begin
                    w_state_d  = StClear;
                    w_cnt_d    = 8'd1;
                    w_length_d = '0;
                end
            end
            default: w_state_d = StClear;
        endcase
    end

    // Outputs are decoded from next state and registered, so they line up with the state register.
    always_comb begin
        w_strb       = '0;
        w_cnt_status = '0;
        w_colour     = COL_BLACK;
        unique case (w_state_d)
            StClear: begin
                if (w_cnt_d == 8'd1) begin
                    w_strb.rst_address = 1'b1;
                end else if (w_cnt_d != 8'd0) begin
                    w_strb.reset_ram   = 1'b1;
                    w_strb.inc_address = 1'b1;
                end
            end
            StInit: begin
                if (w_cnt_d == 8'd0) begin
                    w_strb.rst_address = 1'b1;
                    w_strb.ld_head     = 1'b1;
                end else begin
                    w_strb.ld_q_def    = 1'b1;
                    w_strb.inc_address = 1'b1;
                end
            end
            StWait:   w_strb.lock = 1'b1;
            StMove:   w_strb.update_head = 1'b1;
            StCheck:  w_strb.check_inc = 1'b1;
            StLdPrev: begin
                w_strb.ld_head_into_prev = 1'b1;
                w_strb.rst_address       = 1'b1;
            end
            StShLd:   w_strb.ld_q_into_curr = 1'b1;
            StShWr:   w_strb.ld_prev_into_q = 1'b1;
            StShMv: begin
                w_strb.ld_curr_into_prev = 1'b1;
                w_strb.inc_address       = 1'b1;
            end
            StTail: begin
                w_strb.draw_curr   = 1'b1;
                w_strb.rst_address = (w_cnt_d == PixLast);
                w_cnt_status       = w_cnt_d[3:0];
            end
            StDraw: begin
                w_strb.draw_q      = 1'b1;
                w_strb.inc_address = (w_cnt_d == PixLast);
                w_cnt_status       = w_cnt_d[3:0];
                w_colour           = (w_seg_d == 7'd0) ? COL_HEAD : COL_SNAKE;
            end
            StFood: begin
                w_strb.food_en = 1'b1;
                w_cnt_status   = w_cnt_d[3:0];
                w_colour       = COL_FOOD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StClear;
            r_cnt        <= '0;
            r_seg        <= '0;
            r_length     <= '0;
            r_dir        <= DIR_UP;
            r_start_q    <= 1'b0;
            r_strb       <= '0;
            r_cnt_status <= '0;
            r_colour     <= COL_BLACK;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_seg        <= w_seg_d;
            r_length     <= w_length_d;
            r_dir        <= w_dir_d;
            r_start_q    <= start;
            r_strb       <= w_strb;
            r_cnt_status <= w_cnt_status;
            r_colour     <= w_colour;
        end
    end

    assign reset_ram         = r_strb.reset_ram;
    assign ld_head           = r_strb.ld_head;
    assign ld_q_def          = r_strb.ld_q_def;
    assign inc_address       = r_strb.inc_address;
    assign rst_address       = r_strb.rst_address;
    assign update_head       = r_strb.update_head;
    assign ld_head_into_prev = r_strb.ld_head_into_prev;
    assign ld_q_into_curr    = r_strb.ld_q_into_curr;
    assign ld_prev_into_q    = r_strb.ld_prev_into_q;
    assign ld_curr_into_prev = r_strb.ld_curr_into_prev;
    assign draw_q            = r_strb.draw_q;
    assign draw_curr         = r_strb.draw_curr;
    assign food_en           = r_strb.food_en;
    assign lock              = r_strb.lock;
    assign check_inc         = r_strb.check_inc;
    assign cnt_status        = r_cnt_status;
    assign colour            = r_colour;
    assign dir               = r_dir;
    assign length            = r_length;

endmodule
